fetch_queue_pc: RTL and testbench

//   Parametrised program-counter and instruction prefetch unit for the MIPS datapath.

---
 rtl/fetch_queue_pc.sv | 125 ++++++++++++
 tb/tb_fetch_queue_pc.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_pc.sv
// Program counter and instruction prefetch queue for the MIPS datapath.
// Issues in-order fetches under a credit limit and buffers {pc, instr} for decode.
module fetch_queue_pc #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DATA_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 PC_INC   = 4
) (
    input  logic                     Clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDR_W-1:0]        imem_req_addr,
    input  logic                     imem_rsp_valid,
    input  logic [DATA_W-1:0]        imem_rsp_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output logic [DATA_W-1:0]        out_instr,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [ADDR_W-1:0] INC   = ADDR_W'(PC_INC);
    localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);
    localparam logic [CNT_W:0]    LIMIT = (CNT_W+1)'(DEPTH);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ret_pc;
    logic [ADDR_W-1:0] redirect_base;

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [DATA_W-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] inflight_after;
    logic [CNT_W:0]   credit_sum;

    logic req_fire;
    logic rsp_ok;
    logic dropping;
    logic push;
    logic pop;

    assign redirect_base  = redirect_pc & ALIGN;
    assign credit_sum     = {1'b0, count} + {1'b0, outstanding};

    assign imem_req_valid = !reset && !redirect_valid && (credit_sum < LIMIT);
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_ok         = imem_rsp_valid && (outstanding != '0);
    assign dropping       = drop_cnt != '0;
    assign inflight_after = outstanding - CNT_W'(rsp_ok);

    assign push = rsp_ok && !dropping && !redirect_valid && !reset;
    assign pop  = out_valid && out_ready && !redirect_valid && !reset;

    assign out_valid = count != '0;
    assign out_pc    = pc_mem[rd_ptr];
    assign out_instr = instr_mem[rd_ptr];
    assign occupancy = count;

    // In-flight responses outlive a flush or reset, so they stay counted
    // as outstanding and are all marked stale in drop_cnt.
    always_ff @(posedge Clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            ret_pc      <= RESET_PC;
            outstanding <= inflight_after;
            drop_cnt    <= inflight_after;
        end else if (redirect_valid) begin
            pc          <= redirect_base;
            ret_pc      <= redirect_base;
            outstanding <= inflight_after;
            drop_cnt    <= inflight_after;
        end else begin
            if (req_fire) begin
                pc <= pc + INC;
            end
            outstanding <= inflight_after + CNT_W'(req_fire);
            if (rsp_ok) begin
                if (dropping) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end else begin
                    ret_pc <= ret_pc + INC;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset || redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= ret_pc;
            instr_mem[wr_ptr] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue_pc.sv
// Bench for fetch_queue_pc: a latency-randomised memory model plus a
// scoreboard of expected PCs, checked as decode pops the queue.
module tb_fetch_queue_pc;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              Clk;
    logic              reset;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_instr;
    logic [2:0]        occupancy;

    fetch_queue_pc #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .PC_INC   (4)
    ) dut (
        .Clk            (Clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .occupancy      (occupancy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_q[$];
    logic [31:0] popped[$];

    int          checks;
    int          errors;
    int          cyc;
    int          occ_m;
    int          drop_m;
    logic [31:0] pc_m;
    bit          armed;
    bit          last_ov;
    bit          prev_stall;
    logic [31:0] prev_addr;

    int ready_pct;
    int ord_pct;
    int lat_min;
    int lat_max;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1234_5678;
    endfunction

    // One clock: drive at the falling edge, sample 1ns later, update model.
    task automatic step(input bit rst, input bit redir, input logic [31:0] rpc);
        bit          rsp;
        bit          exp_rv;
        bit          fire;
        logic [31:0] raddr;
        logic [31:0] h;
        @(negedge Clk);
        reset          = rst;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = int'($urandom_range(99)) < ready_pct;
        out_ready      = int'($urandom_range(99)) < ord_pct;
        rsp   = 1'b0;
        raddr = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rsp   = 1'b1;
            raddr = pend[0].addr;
            void'(pend.pop_front());
        end
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? word_of(raddr) : '0;
        #1;
        exp_rv = !rst && !redir &&
                 (occ_m + pend.size() + int'(rsp) < DEPTH);
        if (armed) begin
            checks++;
            if (occupancy !== 3'(occ_m)) begin
                errors++;
                $display("FAIL occupancy: got %0d expected %0d", occupancy, occ_m);
            end
            checks++;
            if (out_valid !== (occ_m != 0)) begin
                errors++;
                $display("FAIL out_valid: got %b expected %b", out_valid, occ_m != 0);
            end
            checks++;
            if (imem_req_valid !== exp_rv) begin
                errors++;
                $display("FAIL req_valid: got %b expected %b", imem_req_valid, exp_rv);
            end
            if (exp_rv) begin
                checks++;
                if (imem_req_addr !== pc_m) begin
                    errors++;
                    $display("FAIL req_addr: got %h expected %h", imem_req_addr, pc_m);
                end
            end
            if (prev_stall && !rst && !redir) begin
                checks++;
                if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL req_hold: got %b/%h expected 1/%h",
                             imem_req_valid, imem_req_addr, prev_addr);
                end
            end
        end
        last_ov    = out_valid;
        fire       = imem_req_valid && imem_req_ready;
        prev_stall = imem_req_valid && !imem_req_ready;
        prev_addr  = imem_req_addr;
        if (rst) begin
            occ_m  = 0;
            drop_m = pend.size();
            exp_q.delete();
            pc_m   = RESET_PC;
            armed  = 1'b1;
        end else if (redir) begin
            occ_m  = 0;
            drop_m = pend.size();
            exp_q.delete();
            pc_m   = rpc & 32'hFFFF_FFFC;
        end else if (armed) begin
            if (occ_m != 0 && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard: got pop of %h expected none", out_pc);
                end else begin
                    h = exp_q.pop_front();
                    checks++;
                    if (out_pc !== h) begin
                        errors++;
                        $display("FAIL out_pc: got %h expected %h", out_pc, h);
                    end
                    checks++;
                    if (out_instr !== word_of(h)) begin
                        errors++;
                        $display("FAIL out_instr: got %h expected %h", out_instr, word_of(h));
                    end
                    popped.push_back(h);
                end
                occ_m--;
            end
            if (rsp) begin
                if (drop_m > 0) drop_m--;
                else occ_m++;
            end
            if (exp_rv && imem_req_ready) begin
                exp_q.push_back(pc_m);
                pc_m = pc_m + 32'd4;
            end
        end
        if (fire) begin
            pend.push_back('{addr: imem_req_addr,
                             due: cyc + int'($urandom_range(lat_max, lat_min))});
        end
        @(posedge Clk);
        cyc++;
    endtask

    task automatic test_reset();
        ready_pct = 100;
        ord_pct   = 100;
        lat_min   = 1;
        lat_max   = 1;
        repeat (3) step(1'b1, 1'b0, '0);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (occupancy !== 3'd0) begin
            errors++;
            $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid);
        end
        checks++;
        if (imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_pc: got %h expected %h", imem_req_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int first;
        first = 0;
        popped.delete();
        for (int i = 1; i <= 14; i++) begin
            step(1'b0, 1'b0, '0);
            if (first == 0 && last_ov) first = i;
        end
        checks++;
        if (first != 3) begin
            errors++;
            $display("FAIL first_valid_latency: got %0d expected 3", first);
        end
        checks++;
        if (popped.size() != 12) begin
            errors++;
            $display("FAIL stream_count: got %0d expected 12", popped.size());
        end
        for (int k = 0; k < popped.size() && k < 12; k++) begin
            checks++;
            if (popped[k] !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stream_pc: got %h expected %h", popped[k], 32'(4 * k));
            end
        end
    endtask

    task automatic test_backpressure();
        repeat (2) step(1'b1, 1'b0, '0);
        ord_pct = 0;
        popped.delete();
        repeat (10) step(1'b0, 1'b0, '0);
        #1;
        checks++;
        if (occupancy !== 3'd4) begin
            errors++;
            $display("FAIL stall_occupancy: got %0d expected 4", occupancy);
        end
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_req_valid: got %b expected 0", imem_req_valid);
        end
        ord_pct = 100;
        repeat (8) step(1'b0, 1'b0, '0);
        checks++;
        if (popped.size() < 5) begin
            errors++;
            $display("FAIL resume_count: got %0d expected >=5", popped.size());
        end
        for (int k = 0; k < popped.size() && k < 5; k++) begin
            checks++;
            if (popped[k] !== 32'(4 * k)) begin
                errors++;
                $display("FAIL resume_pc: got %h expected %h", popped[k], 32'(4 * k));
            end
        end
    endtask

    task automatic test_redirect();
        int n;
        repeat (2) step(1'b1, 1'b0, '0);
        lat_min = 3;
        lat_max = 3;
        n = 0;
        while (pend.size() != 2 && n < 20) begin
            step(1'b0, 1'b0, '0);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL redirect_setup: got timeout expected 2 outstanding");
        end
        step(1'b0, 1'b1, 32'h24);
        popped.delete();
        repeat (12) step(1'b0, 1'b0, '0);
        checks++;
        if (popped.size() < 2) begin
            errors++;
            $display("FAIL redirect_count: got %0d expected >=2", popped.size());
        end else begin
            checks++;
            if (popped[0] !== 32'h24) begin
                errors++;
                $display("FAIL redirect_pc0: got %h expected 00000024", popped[0]);
            end
            checks++;
            if (popped[1] !== 32'h28) begin
                errors++;
                $display("FAIL redirect_pc1: got %h expected 00000028", popped[1]);
            end
        end
    endtask

    task automatic test_align_and_reset();
        lat_min = 1;
        lat_max = 2;
        step(1'b0, 1'b1, 32'h27);
        #1;
        checks++;
        if (imem_req_addr !== 32'h24) begin
            errors++;
            $display("FAIL align_addr: got %h expected 00000024", imem_req_addr);
        end
        repeat (5) step(1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 32'h80);
        #1;
        checks++;
        if (imem_req_addr !== RESET_PC) begin
            errors++;
            $display("FAIL reset_wins_pc: got %h expected %h", imem_req_addr, RESET_PC);
        end
        checks++;
        if (occupancy !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_wins_fifo: got %0d/%b expected 0/0", occupancy, out_valid);
        end
        popped.delete();
        repeat (10) step(1'b0, 1'b0, '0);
        checks++;
        if (popped.size() < 2) begin
            errors++;
            $display("FAIL reset_wins_count: got %0d expected >=2", popped.size());
        end else begin
            checks++;
            if (popped[0] !== RESET_PC || popped[1] !== RESET_PC + 32'd4) begin
                errors++;
                $display("FAIL reset_wins_stream: got %h,%h expected %h,%h",
                         popped[0], popped[1], RESET_PC, RESET_PC + 32'd4);
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] want [4];
        want[0] = 32'hFFFF_FFF8;
        want[1] = 32'hFFFF_FFFC;
        want[2] = 32'h0000_0000;
        want[3] = 32'h0000_0004;
        lat_min = 1;
        lat_max = 1;
        step(1'b0, 1'b1, 32'hFFFF_FFF8);
        popped.delete();
        repeat (10) step(1'b0, 1'b0, '0);
        checks++;
        if (popped.size() < 4) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected >=4", popped.size());
        end
        for (int k = 0; k < popped.size() && k < 4; k++) begin
            checks++;
            if (popped[k] !== want[k]) begin
                errors++;
                $display("FAIL wrap_pc: got %h expected %h", popped[k], want[k]);
            end
        end
    endtask

    task automatic test_random();
        int r;
        ready_pct = 60;
        ord_pct   = 70;
        lat_min   = 1;
        lat_max   = 3;
        popped.delete();
        for (int i = 0; i < 800; i++) begin
            r = int'($urandom_range(999));
            if (r < 4) step(1'b1, 1'b0, '0);
            else if (r < 25) step(1'b0, 1'b1, $urandom);
            else step(1'b0, 1'b0, '0);
        end
        checks++;
        if (popped.size() < 100) begin
            errors++;
            $display("FAIL random_progress: got %0d expected >=100", popped.size());
        end
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        out_ready      = 1'b0;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        occ_m      = 0;
        drop_m     = 0;
        pc_m       = RESET_PC;
        armed      = 1'b0;
        last_ov    = 1'b0;
        prev_stall = 1'b0;
        prev_addr  = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_align_and_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
